// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
//   Parametrised up/down event/tick counter with load, synchronous clear,
//   direction control, wrap-or-saturate limit handling, a one-cycle registered
//   terminal-count pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   MODULO    count range 0..MODULO-1, 2 <= MODULO <= 2**WIDTH
//   SATURATE  0: wrap at the limits, 1: hold at the limits
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset (clears out, tc, ovf)
//   clear     synchronous clear to 0, highest synchronous priority
//   load      synchronous load of load_val (clamped to MODULO-1)
//   load_val  load value
//   enable    count enable
//   up_dn     1 = increment, 0 = decrement
//   out       current count (registered)
//   tc        terminal-count pulse, one cycle (registered)
//   ovf       sticky flag, set on any wrap or saturate hit
// -----------------------------------------------------------------------------
module updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULO   = 2 ** WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             up_dn,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    // Upper limit of the count range, held in WIDTH bits so every compare is
    // done at counter width. For non-power-of-2 MODULO the values above this
    // are never produced: increments stop here and loads are clamped.
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Clamp a requested load value into the legal count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] result;
        if (value > MAX_VAL) begin
            result = MAX_VAL;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Value reached by an enabled step that crosses a limit; in saturate mode
    // the counter stays where it is, otherwise it jumps to the opposite limit.
    function automatic logic [WIDTH-1:0] limit_next(input logic [WIDTH-1:0] current,
                                                    input logic [WIDTH-1:0] wrapped);
        logic [WIDTH-1:0] result;
        if (SATURATE) begin
            result = current;
        end else begin
            result = wrapped;
        end
        return result;
    endfunction

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             ovf_r;

    logic [WIDTH-1:0] count_next_s;
    logic             tc_next_s;
    logic             ovf_next_s;
    logic             at_max_s;
    logic             at_zero_s;

    assign at_max_s  = (count_r == MAX_VAL);
    assign at_zero_s = (count_r == ZERO_VAL);

    // Next-state selection: clear > load > enabled step > hold.
    always_comb begin
        count_next_s = count_r;
        tc_next_s    = 1'b0;
        ovf_next_s   = ovf_r;

        if (clear) begin
            count_next_s = ZERO_VAL;
            tc_next_s    = 1'b0;
            ovf_next_s   = 1'b0;
        end else if (load) begin
            count_next_s = clamp_load(load_val);
            tc_next_s    = 1'b0;
        end else if (enable) begin
            if (up_dn) begin
                if (at_max_s) begin
                    count_next_s = limit_next(count_r, ZERO_VAL);
                    tc_next_s    = 1'b1;
                    ovf_next_s   = 1'b1;
                end else begin
                    count_next_s = count_r + ONE_VAL;
                end
            end else begin
                if (at_zero_s) begin
                    count_next_s = limit_next(count_r, MAX_VAL);
                    tc_next_s    = 1'b1;
                    ovf_next_s   = 1'b1;
                end else begin
                    count_next_s = count_r - ONE_VAL;
                end
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // State registers; reset overrides everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= ZERO_VAL;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            tc_r    <= tc_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    assign out = count_r;
    assign tc  = tc_r;
    assign ovf = ovf_r;

endmodule

// File: tb/tb_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_counter
//   Directed bench for updown_counter. Three instances share one stimulus:
//     d0: WIDTH=8, MODULO=256, wrap
//     d1: WIDTH=8, MODULO=10,  wrap
//     d2: WIDTH=8, MODULO=10,  saturate
//   Outputs are sampled 1 ns after the rising edge. A closing random run is
//   compared against a small behavioural model of each instance.
// -----------------------------------------------------------------------------
module tb_updown_counter;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       enable;
    logic       up_dn;

    logic [7:0] out0, out1, out2;
    logic       tc0, tc1, tc2;
    logic       ovf0, ovf1, ovf2;

    int errors;
    int checks;

    // model state for the random run
    int m_out [3];
    int m_tc  [3];
    int m_ovf [3];
    int m_mod [3];
    int m_sat [3];

    updown_counter #(.WIDTH(8), .MODULO(256), .SATURATE(1'b0)) d0 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .enable(enable), .up_dn(up_dn), .out(out0), .tc(tc0), .ovf(ovf0)
    );

    updown_counter #(.WIDTH(8), .MODULO(10), .SATURATE(1'b0)) d1 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .enable(enable), .up_dn(up_dn), .out(out1), .tc(tc1), .ovf(ovf1)
    );

    updown_counter #(.WIDTH(8), .MODULO(10), .SATURATE(1'b1)) d2 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .enable(enable), .up_dn(up_dn), .out(out2), .tc(tc2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic get_dut(input int i, output logic [31:0] o, output logic [31:0] t,
                           output logic [31:0] v);
        case (i)
            0: begin o = {24'd0, out0}; t = {31'd0, tc0}; v = {31'd0, ovf0}; end
            1: begin o = {24'd0, out1}; t = {31'd0, tc1}; v = {31'd0, ovf1}; end
            default: begin o = {24'd0, out2}; t = {31'd0, tc2}; v = {31'd0, ovf2}; end
        endcase
    endtask

    task automatic model_step(input int i);
        int lim;
        lim = m_mod[i] - 1;
        if (clear) begin
            m_out[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
        end else if (load) begin
            m_out[i] = (int'(load_val) > lim) ? lim : int'(load_val);
            m_tc[i]  = 0;
        end else if (enable && up_dn) begin
            if (m_out[i] == lim) begin
                m_tc[i] = 1; m_ovf[i] = 1;
                if (m_sat[i] == 0) m_out[i] = 0;
            end else begin
                m_out[i] = m_out[i] + 1; m_tc[i] = 0;
            end
        end else if (enable) begin
            if (m_out[i] == 0) begin
                m_tc[i] = 1; m_ovf[i] = 1;
                if (m_sat[i] == 0) m_out[i] = lim;
            end else begin
                m_out[i] = m_out[i] - 1; m_tc[i] = 0;
            end
        end else begin
            m_tc[i] = 0;
        end
    endtask

    initial begin
        logic [31:0] o, t, v;
        errors   = 0;
        checks   = 0;
        reset    = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 8'd0;
        enable   = 1'b0;
        up_dn    = 1'b1;
        m_mod    = '{256, 10, 10};
        m_sat    = '{0, 0, 1};
        m_out    = '{0, 0, 0};
        m_tc     = '{0, 0, 0};
        m_ovf    = '{0, 0, 0};

        // reset state, held across edges
        #1;
        chk("rst_out0", {24'd0, out0}, 32'd0);
        chk("rst_tc0", {31'd0, tc0}, 32'd0);
        chk("rst_ovf0", {31'd0, ovf0}, 32'd0);
        step();
        step();
        chk("rst_hold_out1", {24'd0, out1}, 32'd0);
        chk("rst_hold_out2", {24'd0, out2}, 32'd0);
        reset = 1'b1;

        // wrap through 255 -> 0 on the full-range instance
        load = 1'b1; load_val = 8'd254;
        step();
        chk("ld254_out0", {24'd0, out0}, 32'd254);
        chk("ld254_out1_clamp", {24'd0, out1}, 32'd9);
        load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        step();
        chk("w_out0_a", {24'd0, out0}, 32'd255);
        chk("w_tc0_a", {31'd0, tc0}, 32'd0);
        chk("w_ovf0_a", {31'd0, ovf0}, 32'd0);
        step();
        chk("w_out0_b", {24'd0, out0}, 32'd0);
        chk("w_tc0_b", {31'd0, tc0}, 32'd1);
        chk("w_ovf0_b", {31'd0, ovf0}, 32'd1);
        step();
        chk("w_out0_c", {24'd0, out0}, 32'd1);
        chk("w_tc0_c", {31'd0, tc0}, 32'd0);
        chk("w_ovf0_c", {31'd0, ovf0}, 32'd1);

        // asynchronous reset mid-count
        enable = 1'b0; load = 1'b1; load_val = 8'd37;
        step();
        chk("mid_out0", {24'd0, out0}, 32'd37);
        load = 1'b0; enable = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_out0", {24'd0, out0}, 32'd0);
        chk("async_tc0", {31'd0, tc0}, 32'd0);
        chk("async_ovf0", {31'd0, ovf0}, 32'd0);
        step();
        chk("async_hold_out0", {24'd0, out0}, 32'd0);
        reset = 1'b1; enable = 1'b0;
        step();
        chk("rel_out0", {24'd0, out0}, 32'd0);

        // MODULO=10 up-count from 0 for 12 edges
        clear = 1'b1;
        step();
        clear = 1'b0; enable = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("m10_out1_%0d", k), {24'd0, out1}, 32'(k % 10));
            chk($sformatf("m10_tc1_%0d", k), {31'd0, tc1}, (k == 10) ? 32'd1 : 32'd0);
            chk($sformatf("sat_out2_%0d", k), {24'd0, out2}, (k <= 9) ? 32'(k) : 32'd9);
            chk($sformatf("sat_tc2_%0d", k), {31'd0, tc2}, (k >= 10) ? 32'd1 : 32'd0);
        end
        chk("m10_ovf1", {31'd0, ovf1}, 32'd1);

        // down from 0
        enable = 1'b0; clear = 1'b1;
        step();
        chk("clr_out1", {24'd0, out1}, 32'd0);
        chk("clr_ovf1", {31'd0, ovf1}, 32'd0);
        clear = 1'b0; enable = 1'b1; up_dn = 1'b0;
        step();
        chk("dn_out1", {24'd0, out1}, 32'd9);
        chk("dn_tc1", {31'd0, tc1}, 32'd1);
        chk("dn_ovf1", {31'd0, ovf1}, 32'd1);
        chk("dn_out2_hold", {24'd0, out2}, 32'd0);
        chk("dn_tc2", {31'd0, tc2}, 32'd1);
        chk("dn_out0", {24'd0, out0}, 32'd255);

        // load clamp
        enable = 1'b0; load = 1'b1; load_val = 8'd15;
        step();
        chk("ld15_out1", {24'd0, out1}, 32'd9);
        chk("ld15_tc1", {31'd0, tc1}, 32'd0);
        chk("ld15_out0", {24'd0, out0}, 32'd15);

        // saturate: load 8, up x4
        load_val = 8'd8;
        step();
        chk("ld8_out2", {24'd0, out2}, 32'd8);
        load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        step();
        chk("s_out2_0", {24'd0, out2}, 32'd9);
        chk("s_tc2_0", {31'd0, tc2}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("s_out2_%0d", k), {24'd0, out2}, 32'd9);
            chk($sformatf("s_tc2_%0d", k), {31'd0, tc2}, 32'd1);
        end
        chk("s_ovf2", {31'd0, ovf2}, 32'd1);

        // priority: clear over load over enable
        enable = 1'b0; load = 1'b1; load_val = 8'd5;
        step();
        chk("p_out1_5", {24'd0, out1}, 32'd5);
        clear = 1'b1; load = 1'b1; load_val = 8'd7; enable = 1'b1; up_dn = 1'b1;
        step();
        chk("p_clr_out0", {24'd0, out0}, 32'd0);
        chk("p_clr_out1", {24'd0, out1}, 32'd0);
        chk("p_clr_ovf2", {31'd0, ovf2}, 32'd0);
        chk("p_clr_tc2", {31'd0, tc2}, 32'd0);
        clear = 1'b0; load_val = 8'd5;
        step();
        chk("p_ld_out1", {24'd0, out1}, 32'd5);
        load_val = 8'd3;
        step();
        chk("p_ld_noinc_out1", {24'd0, out1}, 32'd3);
        chk("p_ld_noinc_out0", {24'd0, out0}, 32'd3);

        // idle with toggling direction
        load = 1'b0; enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            up_dn = k[0];
            step();
            chk($sformatf("idle_out1_%0d", k), {24'd0, out1}, 32'd3);
            chk($sformatf("idle_tc1_%0d", k), {31'd0, tc1}, 32'd0);
            chk($sformatf("idle_out2_%0d", k), {24'd0, out2}, 32'd3);
        end

        // random run against the behavioural model
        for (int n = 0; n < 300; n++) begin
            clear    = (n == 0) || ($urandom_range(0, 19) == 0);
            load     = ($urandom_range(0, 9) == 0);
            enable   = ($urandom_range(0, 3) != 0);
            up_dn    = ($urandom_range(0, 2) != 0);
            load_val = 8'($urandom_range(0, 255));
            step();
            for (int i = 0; i < 3; i++) begin
                model_step(i);
                get_dut(i, o, t, v);
                chk($sformatf("rnd%0d_out_%0d", i, n), o, 32'(m_out[i]));
                chk($sformatf("rnd%0d_tc_%0d", i, n), t, 32'(m_tc[i]));
                chk($sformatf("rnd%0d_ovf_%0d", i, n), v, 32'(m_ovf[i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
